// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer and its button front end.
package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  // Bit n set: entering mode n reloads led with 1; clear: reloads all-zero.
  localparam logic [3:0] RELOAD_LSB = 4'b0111;

endpackage

// File: rtl/led_seq_btn_debounce.sv
// Button front end: two-flop synchroniser, stability counter and rising-edge press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: prescaled step ticks, button-selected display mode.
// state  | meaning
// ROT_L  | single lit LED rotating towards the MSB
// ROT_R  | single lit LED rotating towards bit 0
// BOUNCE | single lit LED sweeping end to end
// BLINK  | whole bank toggling each step
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV  = 5000000,
  parameter int DB_CYCLES = 200000,
  parameter int LED_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              pause,
  input  logic [1:0]        speed,
  output logic [LED_W-1:0]  led,
  output logic [MODE_W-1:0] mode,
  output logic              tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int PW    = CNT_W + 1;
  localparam logic [PW-1:0] TICK_DIV_V = PW'(TICK_DIV);

  logic             press;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [PW-1:0]    period;
  logic             step_now;

  mode_t            mode_q, mode_d;
  dir_t             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn),
    .press  (press)
  );

  // ">=" rather than "==" so a speed-up that lands below the count still wraps.
  always_comb begin
    period   = TICK_DIV_V >> speed;
    step_now = !pause && ({1'b0, cnt_q} >= (period - PW'(1)));
    tick_d   = step_now;
    cnt_d    = cnt_q;
    if (press || step_now) begin
      cnt_d = '0;
    end else if (!pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= ROT_L;
      dir_q  <= LEFT;
      led_q  <= LED_W'(1);
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
    end
  end

  // A press on a tick cycle discards that step.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    led_d  = led_q;
    if (press) begin
      mode_d = mode_t'(mode_q + MODE_W'(1));
      dir_d  = LEFT;
      led_d  = RELOAD_LSB[mode_d] ? LED_W'(1) : '0;
    end else if (step_now) begin
      case (mode_q)
        ROT_L:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        ROT_R:  led_d = {led_q[0], led_q[LED_W-1:1]};
        BOUNCE: begin
          if (dir_q == LEFT) begin
            if (led_q[LED_W-1]) begin
              dir_d = RIGHT;
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              dir_d = LEFT;
              led_d = led_q << 1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        BLINK:   led_d = ~led_q;
        default: led_d = led_q;
      endcase
    end
  end

  always_comb begin
    led  = led_q;
    mode = mode_q;
    tick = tick_q;
  end

endmodule
